// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types for the unified-memory arbiter (FSM states, requester codes).
// Revision: 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } sel_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_counter
// Purpose : Counts down the fixed memory latency; done flags the last ACCESS cycle.
// Revision: 1.0  initial release
// ============================================================================
module mem_wait_counter #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic done
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(LATENCY - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= C_LOAD_VAL;
      end else if (dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one fixed-latency single-port memory between fetch (I) and load/store (D).
// Revision: 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hlt,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            r_state;
   state_t            w_state_nxt;
   sel_t              r_sel;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_wr;
   logic              r_last_d;

   logic              w_elig_i;
   logic              w_grant_d;
   logic              w_grant;
   logic              w_sample;
   logic              w_in_access;
   logic              w_cnt_done;

   // D wins a contended IDLE cycle unless it won the previous grant.
   assign w_elig_i  = i_req & ~hlt;
   assign w_grant_d = d_req & (~w_elig_i | ~r_last_d);

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_sample    = 1'b0;
      w_in_access = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (d_req || w_elig_i) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_in_access = 1'b1;
            if (w_cnt_done) begin
               w_sample    = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= SEL_I;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wr     <= 1'b0;
         r_last_d <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_sel    <= w_grant_d ? SEL_D : SEL_I;
            r_addr   <= w_grant_d ? d_addr : i_addr;
            r_wr     <= w_grant_d & d_wr;
            r_wdata  <= d_wdata;
            r_last_d <= w_grant_d;
         end
         if (w_sample && !r_wr) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   mem_wait_counter #(
      .LATENCY (LATENCY)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_grant),
      .dec   (w_in_access),
      .done  (w_cnt_done)
   );

   // Strobes decode from the state register so an async reset drops them at once.
   assign mem_en    = (r_state == ST_ACCESS);
   assign mem_wr    = mem_en & r_wr;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   assign i_ack   = (r_state == ST_RESP) && (r_sel == SEL_I);
   assign d_ack   = (r_state == ST_RESP) && (r_sel == SEL_D);
   assign i_rdata = r_rdata;
   assign d_rdata = r_rdata;

   assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed self-checking bench for mem_arbiter (LATENCY=4 and LATENCY=1 builds).
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        hlt;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_ack;
   logic [15:0] i_rdata;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        stall;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic        i_ack_1;
   logic [15:0] i_rdata_1;
   logic        d_req_1;
   logic [15:0] d_addr_1;
   logic        d_ack_1;
   logic [15:0] d_rdata_1;
   logic        stall_1;
   logic        mem_en_1;
   logic        mem_wr_1;
   logic [15:0] mem_addr_1;
   logic [15:0] mem_wdata_1;
   logic [15:0] mem_rdata_1;
   logic        zero_1;
   logic [15:0] zero_16;

   int n_total;
   int n_pass;
   int n_fail;

   // Memory stub: read data is the address XOR a fixed pattern.
   assign mem_rdata   = mem_addr ^ 16'hA5B5;
   assign mem_rdata_1 = mem_addr_1 ^ 16'hA5B5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .hlt(hlt),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .hlt(zero_1),
      .i_req(zero_1), .i_addr(zero_16), .i_ack(i_ack_1), .i_rdata(i_rdata_1),
      .d_req(d_req_1), .d_wr(zero_1), .d_addr(d_addr_1), .d_wdata(zero_16),
      .d_ack(d_ack_1), .d_rdata(d_rdata_1), .stall(stall_1),
      .mem_en(mem_en_1), .mem_wr(mem_wr_1), .mem_addr(mem_addr_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] l1_addr [3];
      logic [15:0] l1_data [3];
      logic        exp_d;

      n_total = 0; n_pass = 0; n_fail = 0;
      zero_1 = 1'b0; zero_16 = 16'h0000;
      rst_n = 1'b0; hlt = 1'b0;
      i_req = 1'b0; i_addr = 16'h0000;
      d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
      d_req_1 = 1'b0; d_addr_1 = 16'h0000;
      l1_addr[0] = 16'h0001; l1_data[0] = 16'hA5B4;
      l1_addr[1] = 16'h0002; l1_data[1] = 16'hA5B7;
      l1_addr[2] = 16'h00FF; l1_data[2] = 16'hA54A;

      // Reset state
      repeat (3) step();
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 16'h0000);
      check("rst_i_ack", i_ack, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_rdata", i_rdata, 16'h0000);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;
      step();

      // Single fetch
      i_addr = 16'h0010; i_req = 1'b1;
      #1;
      check("t1_stall_idle", stall, 1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t1_mem_en", mem_en, 1);
         check("t1_i_ack_wait", i_ack, 0);
      end
      check("t1_mem_addr", mem_addr, 16'h0010);
      check("t1_mem_wr", mem_wr, 0);
      step();
      check("t1_i_ack", i_ack, 1);
      check("t1_i_rdata", i_rdata, 16'hA5A5);
      check("t1_d_ack", d_ack, 0);
      check("t1_mem_en_resp", mem_en, 0);
      check("t1_stall_resp", stall, 0);
      i_req = 1'b0;
      step();
      check("t1_i_ack_pulse", i_ack, 0);

      // Single write
      d_addr = 16'h0200; d_wdata = 16'h1234; d_wr = 1'b1; d_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t2_mem_en", mem_en, 1);
         check("t2_mem_wr", mem_wr, 1);
      end
      check("t2_mem_addr", mem_addr, 16'h0200);
      check("t2_mem_wdata", mem_wdata, 16'h1234);
      step();
      check("t2_d_ack", d_ack, 1);
      check("t2_i_ack", i_ack, 0);
      check("t2_mem_wr_resp", mem_wr, 0);
      check("t2_rdata_kept", d_rdata, 16'hA5A5);
      d_req = 1'b0; d_wr = 1'b0;
      step();
      check("t2_d_ack_pulse", d_ack, 0);

      // Contention from reset: D, I, D, I
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      i_addr = 16'h0010; d_addr = 16'h0300; d_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
         exp_d = ((j % 2) == 0);
         step();
         check("t3_mem_en", mem_en, 1);
         check("t3_mem_addr", mem_addr, exp_d ? 16'h0300 : 16'h0010);
         repeat (3) step();
         step();
         check("t3_d_ack", d_ack, exp_d);
         check("t3_i_ack", i_ack, !exp_d);
         check("t3_rdata", d_rdata, exp_d ? 16'hA6B5 : 16'hA5A5);
         step();
         check("t3_idle_acks", {i_ack, d_ack, mem_en}, 3'b000);
      end
      i_req = 1'b0; d_req = 1'b0;
      step();

      // Halt: only D served, fetch stalls
      hlt = 1'b1; i_req = 1'b1; d_req = 1'b1; d_addr = 16'h0300;
      step();
      check("t4_d_granted", mem_addr, 16'h0300);
      repeat (3) step();
      check("t4_stall_access", stall, 1);
      step();
      check("t4_d_ack", d_ack, 1);
      check("t4_i_ack_resp", i_ack, 0);
      check("t4_stall_resp", stall, 1);
      d_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         check("t4_halted", {i_ack, mem_en, stall}, 3'b001);
      end
      hlt = 1'b0;
      step();
      check("t4_i_granted", {mem_en, mem_addr}, {1'b1, 16'h0010});
      repeat (4) step();
      check("t4_i_ack", i_ack, 1);
      i_req = 1'b0;
      step();

      // Reset during the 2nd ACCESS cycle of a write
      d_addr = 16'h0400; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
      step();
      step();
      check("t5_pre_mem_wr", mem_wr, 1);
      rst_n = 1'b0;
      #1;
      check("t5_mem_en_drop", mem_en, 0);
      check("t5_mem_wr_drop", mem_wr, 0);
      d_req = 1'b0; d_wr = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("t5_no_ack", {d_ack, i_ack, mem_en}, 3'b000);
      end

      // LATENCY=1 back-to-back reads: ack every 3 cycles
      d_addr_1 = l1_addr[0]; d_req_1 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         check("t6_mem_en", mem_en_1, 1);
         check("t6_d_ack_early", d_ack_1, 0);
         step();
         check("t6_d_ack", d_ack_1, 1);
         check("t6_d_rdata", d_rdata_1, l1_data[j]);
         check("t6_mem_en_resp", mem_en_1, 0);
         if (j < 2) d_addr_1 = l1_addr[j + 1];
         else d_req_1 = 1'b0;
         step();
         check("t6_idle", d_ack_1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
